// File: rtl/counter_pkg.sv
// Shared types for the loadable up/down counter: end-of-range modes and
// the two-state run/frozen control FSM.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/counter_updown_mod.sv
// Parametrised loadable up/down counter with programmable upper endpoint,
// wrap / saturate / one-shot end-of-range behaviour, a one-cycle endpoint
// pulse and a sticky wrap overflow flag.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             at_end,
  output logic             end_pulse,
  output logic             overflow,
  output logic             done
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VALUE);

  state_e           state, state_nxt;
  mode_e            mode_sel;
  logic [WIDTH-1:0] count_nxt;
  logic             pulse_nxt;
  logic             ovf_nxt;

  // The reserved encoding decodes as wrap in the case below.
  assign mode_sel = mode_e'(mode);

  // Up uses >= so a count loaded above limit is already at its endpoint.
  assign at_end = up_down ? (count >= limit) : (count == '0);

  assign done = (state == ST_DONE);

  // Endpoint handling and next-count selection; load overrides any step.
  always_comb begin
    count_nxt = count;
    state_nxt = state;
    pulse_nxt = 1'b0;
    ovf_nxt   = overflow & ~clr_ovf;
    if (load) begin
      count_nxt = load_data;
      state_nxt = ST_RUN;
    end else if (en && (state == ST_RUN)) begin
      if (at_end) begin
        pulse_nxt = 1'b1;
        case (mode_sel)
          MODE_SAT: count_nxt = count;
          MODE_ONESHOT: state_nxt = ST_DONE;
          default: begin
            count_nxt = up_down ? '0 : limit;
            ovf_nxt   = 1'b1;
          end
        endcase
      end else begin
        count_nxt = up_down ? (count + 1'b1) : (count - 1'b1);
      end
    end
  end

  // All state registers; synchronous reset takes priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= RST_COUNT;
      state     <= ST_RUN;
      end_pulse <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      count     <= count_nxt;
      state     <= state_nxt;
      end_pulse <= pulse_nxt;
      overflow  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod (WIDTH=4, RESET_VALUE=0).
// The driver applies one directed vector per cycle on the falling edge and
// queues the hand-computed post-edge state; the monitor pops one entry
// after every rising edge and compares.
module tb_counter_updown_mod;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         up_down = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] limit = '0;
  logic         load = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         clr_ovf = 1'b0;
  logic [W-1:0] count;
  logic         at_end;
  logic         end_pulse;
  logic         overflow;
  logic         done;

  typedef struct {
    int          idx;
    logic [W-1:0] cnt;
    logic        pls;
    logic        ovf;
    logic        dn;
    int          ae;   // -1: not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_no = 0;
  bit   stim_done = 0;

  counter_updown_mod #(.WIDTH(W), .RESET_VALUE(0)) dut (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .mode(mode),
    .limit(limit), .load(load), .load_data(load_data), .clr_ovf(clr_ovf),
    .count(count), .at_end(at_end), .end_pulse(end_pulse),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s vec%0d: got %0d expected %0d", nm, idx, act, req);
    end
  endtask

  // Drive one vector and queue the expected state after the next rising edge.
  task automatic v(input logic r, input logic e, input logic ud, input logic [1:0] md,
                   input int lim, input logic ld, input int ldd, input logic clr,
                   input int ecnt, input logic epls, input logic eovf, input logic edn,
                   input int eae);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; up_down = ud; mode = md; limit = W'(lim);
    load = ld; load_data = W'(ldd); clr_ovf = clr;
    x.idx = vec_no; x.cnt = W'(ecnt); x.pls = epls; x.ovf = eovf; x.dn = edn; x.ae = eae;
    exp_q.push_back(x);
    vec_no++;
  endtask

  // Monitor: compare after each rising edge whenever an expectation is queued.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count",     x.idx, int'(count),     int'(x.cnt));
        chk("end_pulse", x.idx, int'(end_pulse), int'(x.pls));
        chk("overflow",  x.idx, int'(overflow),  int'(x.ovf));
        chk("done",      x.idx, int'(done),      int'(x.dn));
        if (x.ae >= 0) chk("at_end", x.idx, int'(at_end), x.ae);
      end
    end
  end

  // Directed stimulus: r  en ud md lim ld ldd clr | cnt pls ovf dn ae
  initial begin
    // reset
    v(1, 0, 1, 2'd0, 5, 0, 0, 0,   0, 0, 0, 0, -1);
    // wrap up, limit 5
    v(0, 1, 1, 2'd0, 5, 0, 0, 0,   1, 0, 0, 0,  0);
    v(0, 1, 1, 2'd0, 5, 0, 0, 0,   2, 0, 0, 0, -1);
    v(0, 1, 1, 2'd0, 5, 0, 0, 0,   3, 0, 0, 0, -1);
    v(0, 1, 1, 2'd0, 5, 0, 0, 0,   4, 0, 0, 0,  0);
    v(0, 1, 1, 2'd0, 5, 0, 0, 0,   5, 0, 0, 0,  1);
    v(0, 1, 1, 2'd0, 5, 0, 0, 0,   0, 1, 1, 0,  0);
    v(0, 0, 1, 2'd0, 5, 0, 0, 1,   0, 0, 0, 0, -1);
    // saturate down from 3 (en ignored during load)
    v(0, 1, 0, 2'd1, 5, 1, 3, 0,   3, 0, 0, 0,  0);
    v(0, 1, 0, 2'd1, 5, 0, 0, 0,   2, 0, 0, 0, -1);
    v(0, 1, 0, 2'd1, 5, 0, 0, 0,   1, 0, 0, 0, -1);
    v(0, 1, 0, 2'd1, 5, 0, 0, 0,   0, 0, 0, 0,  1);
    v(0, 1, 0, 2'd1, 5, 0, 0, 0,   0, 1, 0, 0,  1);
    v(0, 1, 0, 2'd1, 5, 0, 0, 0,   0, 1, 0, 0, -1);
    v(0, 0, 0, 2'd1, 5, 0, 0, 0,   0, 0, 0, 0, -1);
    // one-shot up, limit 2
    v(0, 0, 1, 2'd2, 2, 1, 0, 0,   0, 0, 0, 0, -1);
    v(0, 1, 1, 2'd2, 2, 0, 0, 0,   1, 0, 0, 0, -1);
    v(0, 1, 1, 2'd2, 2, 0, 0, 0,   2, 0, 0, 0,  1);
    v(0, 1, 1, 2'd2, 2, 0, 0, 0,   2, 1, 0, 1, -1);
    v(0, 1, 1, 2'd2, 2, 0, 0, 0,   2, 0, 0, 1, -1);
    v(0, 1, 1, 2'd0, 2, 0, 0, 0,   2, 0, 0, 1, -1);
    v(0, 0, 1, 2'd2, 2, 1, 7, 0,   7, 0, 0, 0,  1);
    v(0, 1, 1, 2'd2, 2, 0, 0, 0,   7, 1, 0, 1, -1);
    // load beats step, reset beats load
    v(0, 1, 1, 2'd0, 15, 1, 9, 0,  9, 0, 0, 0, -1);
    v(0, 1, 1, 2'd0, 15, 0, 0, 0, 10, 0, 0, 0, -1);
    v(1, 1, 1, 2'd0, 15, 1, 5, 0,  0, 0, 0, 0, -1);
    // wrap down, limit 0xA
    v(0, 1, 0, 2'd0, 10, 0, 0, 0, 10, 1, 1, 0, -1);
    v(0, 1, 0, 2'd0, 10, 0, 0, 0,  9, 0, 1, 0, -1);
    v(0, 1, 0, 2'd0, 10, 1, 0, 0,  0, 0, 1, 0, -1);
    // limit 0: every step is an endpoint step; set wins over clear
    v(0, 1, 1, 2'd0, 0, 0, 0, 1,   0, 1, 1, 0,  1);
    v(0, 1, 1, 2'd3, 0, 0, 0, 0,   0, 1, 1, 0, -1);
    v(0, 1, 1, 2'd0, 0, 0, 0, 0,   0, 1, 1, 0, -1);
    v(0, 0, 1, 2'd0, 0, 0, 0, 1,   0, 0, 0, 0, -1);
    // loaded above limit: first up step wraps to 0
    v(0, 0, 1, 2'd0, 5, 1, 12, 0, 12, 0, 0, 0,  1);
    v(0, 1, 1, 2'd0, 5, 0, 0, 0,   0, 1, 1, 0, -1);
    // reset out of DONE
    v(0, 0, 1, 2'd2, 1, 1, 1, 0,   1, 0, 1, 0, -1);
    v(0, 1, 1, 2'd2, 1, 0, 0, 0,   1, 1, 1, 1, -1);
    v(1, 1, 1, 2'd2, 1, 0, 0, 0,   0, 0, 0, 0, -1);
    v(0, 0, 1, 2'd0, 1, 0, 0, 0,   0, 0, 0, 0, -1);
    stim_done = 1;
  end

  // Drain the scoreboard within a bounded number of cycles, then summarise.
  initial begin
    int guard;
    wait (stim_done);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised loadable up/down counter; successor to the fixed 4-bit load/increment counter.
- Adds enable, direction control, programmable modulus (limit), three end-of-range modes (wrap, saturate, one-shot), endpoint event pulse and sticky overflow flag.
- Used as a general timer/sequencer counter by control blocks in the same clock domain.

Parameters:
- WIDTH, 8, counter width in bits (>= 2)
- RESET_VALUE, 0, value loaded into count on reset (must be <= 2**WIDTH-1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  count enable; one step per cycle while high
- up_down  in  1  1 = count up, 0 = count down
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
- limit  in  WIDTH  upper endpoint; range is 0..limit
- load  in  1  synchronous load of load_data
- load_data  in  WIDTH  value to load
- clr_ovf  in  1  clears sticky overflow
- count  out  WIDTH  current count (registered)
- at_end  out  1  combinational: count at active endpoint (up: count >= limit; down: count == 0)
- end_pulse  out  1  registered one-cycle pulse: an endpoint step occurred last cycle
- overflow  out  1  sticky: set on any endpoint step in wrap mode
- done  out  1  one-shot finished; counter frozen

Behaviour:
- Reset (synchronous, active-high): count=RESET_VALUE, end_pulse=0, overflow=0, done=0, FSM=RUN.
- Priority per cycle: reset > load > step.
- load: count<=load_data next edge, done<=0, FSM<=RUN, end_pulse<=0; en ignored that cycle; overflow unaffected. load_data > limit is permitted.
- Step (en=1, no load, FSM=RUN):
  - Not at endpoint: up: count+1; down: count-1; modulo 2**WIDTH arithmetic never reached except via endpoint rules.
  - Endpoint step (at_end=1 when en sampled): end_pulse<=1 next cycle. Then by mode:
    - wrap: up -> 0; down -> limit; overflow<=1.
    - saturate: count holds.
    - one-shot: count holds; FSM<=DONE; done<=1.
- Up count loaded above limit: at_end=1 immediately; first step is an endpoint step (wrap -> 0).
- limit=0: every enabled step is an endpoint step; count stays 0 (wrap/saturate).
- en=0: count holds, end_pulse<=0.
- FSM states: RUN (counts), DONE (frozen; en ignored; only load or reset returns to RUN). mode change while in DONE does not leave DONE.
- overflow: set in wrap endpoint step; clr_ovf clears; simultaneous set and clear -> set wins.
- end_pulse: exactly one cycle per endpoint step; back-to-back endpoint steps (limit=0) keep it high continuously.
- Direction/mode/limit sampled every cycle; changes take effect on next step with no pipeline latency.
- Reset mid-count or in DONE: returns to reset state on the next edge regardless of other inputs.

Decomposition:
- Package counter_pkg: mode typedef enum (MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD), FSM state typedef (ST_RUN, ST_DONE).
- Single module; no sub-module needed. Endpoint detection and next-count mux kept as combinational always block, registers in one sequential block.

Test Plan:
- WIDTH=4, reset high one cycle -> count=0, end_pulse=0, overflow=0, done=0.
- Wrap up, limit=5, en=1 from 0 -> count 0,1,2,3,4,5,0; end_pulse high cycle after 5->0; overflow=1; clr_ovf -> overflow=0.
- Saturate down, load 3, en=1 -> count 3,2,1,0,0,0; end_pulse single cycle after first hold at 0, then continuous while en held at endpoint; overflow stays 0.
- One-shot up, limit=2, load 0 -> count 0,1,2, done=1, count frozen at 2 with en=1; load 7 -> done=0, count=7, next step (at_end) -> done=1, count 7 held.
- Simultaneous load=1 and en=1, load_data=9 -> count=9 (no step); reset=1 with load=1 -> count=RESET_VALUE.
- Wrap down, limit=0xA, count=0, en=1 -> count=0xA, overflow=1; limit=0 with en -> count stays 0, end_pulse constantly high.
